// File: rtl/decryption_job_scheduler.sv
// Sequences one decryption job at a time: programs key and select registers, then gates a fixed-length
// word stream into decryption_top. Define READBACK_VERIFY_EN to read back and verify each register write.
module decryption_job_scheduler #(
  parameter int                     addr_witdth      = 8,
  parameter int                     reg_width        = 16,
  parameter int                     MST_DWIDTH       = 32,
  parameter logic [addr_witdth-1:0] SELECT_ADDR      = 8'h00,
  parameter logic [addr_witdth-1:0] CAESAR_KEY_ADDR  = 8'h10,
  parameter logic [addr_witdth-1:0] SCYTALE_KEY_ADDR = 8'h12,
  parameter logic [addr_witdth-1:0] ZIGZAG_KEY_ADDR  = 8'h14,
  parameter int                     REG_TIMEOUT      = 16,
  parameter int                     DRAIN_CYCLES     = 4
) (
  input  logic                   clk_mst,
  input  logic                   rst_n,
  input  logic                   job_valid_i,
  output logic                   job_ready_o,
  input  logic [1:0]             job_alg_i,
  input  logic [reg_width-1:0]   job_key_i,
  input  logic [15:0]            job_len_i,
  input  logic [MST_DWIDTH-1:0]  src_data_i,
  input  logic                   src_valid_i,
  output logic                   src_ready_o,
  output logic [MST_DWIDTH-1:0]  data_o,
  output logic                   valid_o,
  input  logic                   busy_i,
  output logic [addr_witdth-1:0] addr,
  output logic                   read,
  output logic                   write,
  output logic [reg_width-1:0]   wdata,
  input  logic [reg_width-1:0]   rdata,
  input  logic                   done,
  input  logic                   error,
  output logic                   job_done_o,
  output logic                   job_err_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_KEY, S_WAIT_KEY, S_RD_KEY, S_WAIT_RD_KEY,
    S_WR_SEL, S_WAIT_SEL, S_RD_SEL, S_WAIT_RD_SEL,
    S_STREAM, S_DRAIN, S_DONE, S_ERR
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             alg_q, alg_d;
  logic [15:0]            len_q, len_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [15:0]            tmo_q, tmo_d;
  logic [7:0]             idl_q, idl_d;
  logic [addr_witdth-1:0] addr_q, addr_d;
  logic [reg_width-1:0]   wdata_q, wdata_d;
  logic [MST_DWIDTH-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   init_q, init_d;
  logic                   hs;

  function automatic logic [addr_witdth-1:0] key_addr(input logic [1:0] alg);
    case (alg)
      2'd0:    return CAESAR_KEY_ADDR;
      2'd1:    return SCYTALE_KEY_ADDR;
      default: return ZIGZAG_KEY_ADDR;
    endcase
  endfunction

  assign hs = src_valid_i & src_ready_o;

`ifndef READBACK_VERIFY_EN
  logic unused_rdata;
  assign unused_rdata = ^rdata;
`endif

  always_ff @(posedge clk_mst) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      alg_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      idl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alg_q   <= alg_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      idl_q   <= idl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      init_q  <= init_d;
    end
  end

  always_comb begin
    state_d = state_q;
    alg_d   = alg_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    idl_d   = idl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    init_d  = 1'b1;
    // A word taken in the same cycle busy_i rises is still forwarded.
    valid_d = hs;
    data_d  = hs ? src_data_i : data_q;
    case (state_q)
      S_IDLE: begin
        if (init_q && job_valid_i) begin
          alg_d = job_alg_i;
          len_d = job_len_i;
          cnt_d = '0;
          if (job_alg_i == 2'd3 || job_len_i == 16'd0) begin
            state_d = S_ERR;
          end else begin
            state_d = S_WR_KEY;
            addr_d  = key_addr(job_alg_i);
            wdata_d = job_key_i;
          end
        end
      end
      S_WR_KEY: begin tmo_d = 16'd1; state_d = S_WAIT_KEY;    end
      S_RD_KEY: begin tmo_d = 16'd1; state_d = S_WAIT_RD_KEY; end
      S_WR_SEL: begin tmo_d = 16'd1; state_d = S_WAIT_SEL;    end
      S_RD_SEL: begin tmo_d = 16'd1; state_d = S_WAIT_RD_SEL; end
      S_WAIT_KEY, S_WAIT_RD_KEY, S_WAIT_SEL, S_WAIT_RD_SEL: begin
        // error beats done when both arrive together
        if (error) begin
          state_d = S_ERR;
        end else if (done) begin
`ifdef READBACK_VERIFY_EN
          if (state_q == S_WAIT_KEY) begin
            state_d = S_RD_KEY;
          end else if (state_q == S_WAIT_SEL) begin
            state_d = S_RD_SEL;
          end else if (rdata != wdata_q) begin
            state_d = S_ERR;
          end else if (state_q == S_WAIT_RD_KEY) begin
            state_d = S_WR_SEL;
            addr_d  = SELECT_ADDR;
            wdata_d = {{(reg_width-2){1'b0}}, alg_q};
          end else begin
            state_d = S_STREAM;
          end
`else
          if (state_q == S_WAIT_KEY) begin
            state_d = S_WR_SEL;
            addr_d  = SELECT_ADDR;
            wdata_d = {{(reg_width-2){1'b0}}, alg_q};
          end else begin
            state_d = S_STREAM;
          end
`endif
        end else if (tmo_q == 16'(REG_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_STREAM: begin
        if (hs) cnt_d = cnt_q + 16'd1;
        if (cnt_q == len_q) begin
          state_d = S_DRAIN;
          idl_d   = '0;
        end
      end
      S_DRAIN: begin
        if (busy_i)                                idl_d   = '0;
        else if (idl_q == 8'(DRAIN_CYCLES - 1))    state_d = S_DONE;
        else                                       idl_d   = idl_q + 8'd1;
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    job_ready_o = init_q && (state_q == S_IDLE);
    write       = (state_q == S_WR_KEY) || (state_q == S_WR_SEL);
`ifdef READBACK_VERIFY_EN
    read        = (state_q == S_RD_KEY) || (state_q == S_RD_SEL);
`else
    read        = 1'b0;
`endif
    src_ready_o = (state_q == S_STREAM) && !busy_i && (cnt_q < len_q);
    job_done_o  = (state_q == S_DONE);
    job_err_o   = (state_q == S_ERR);
    addr        = addr_q;
    wdata       = wdata_q;
    data_o      = data_q;
    valid_o     = valid_q;
  end

endmodule

// File: tb/tb_decryption_job_scheduler.sv
// Scoreboard bench for decryption_job_scheduler: randomized jobs, a regfile responder and a busy/source model.
module tb_decryption_job_scheduler;
  localparam int RT = 16;
  localparam int DC = 4;

  logic        clk_mst = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid_i = 1'b0;
  logic        job_ready_o;
  logic [1:0]  job_alg_i = '0;
  logic [15:0] job_key_i = '0;
  logic [15:0] job_len_i = '0;
  logic [31:0] src_data_i = '0;
  logic        src_valid_i = 1'b0;
  logic        src_ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        busy_i = 1'b0;
  logic [7:0]  addr;
  logic        read, write;
  logic [15:0] wdata;
  logic [15:0] rdata = '0;
  logic        done = 1'b0, error = 1'b0;
  logic        job_done_o, job_err_o;

  decryption_job_scheduler dut (
    .clk_mst(clk_mst), .rst_n(rst_n),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_alg_i(job_alg_i),
    .job_key_i(job_key_i), .job_len_i(job_len_i),
    .src_data_i(src_data_i), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .data_o(data_o), .valid_o(valid_o), .busy_i(busy_i),
    .addr(addr), .read(read), .write(write), .wdata(wdata), .rdata(rdata),
    .done(done), .error(error), .job_done_o(job_done_o), .job_err_o(job_err_o)
  );

  always #5 clk_mst = ~clk_mst;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  logic rst_q = 1'b0;
  logic [23:0] exp_wr[$];
  logic [31:0] exp_word[$];
  bit          exp_end[$];
  logic [31:0] src_q[$];
  bit   hs_seen = 0;
  int   taken = 0, busy_hold = 0, idle_run = 0;
  int   first_wr_cyc = -1, last_wr_cyc = 0, first_hs_cyc = -1, acc_cyc = 0, end_cyc = 0;
  bit   rand_busy = 0, src_gaps = 0, busy_after_first = 0, rf_err_key = 0;
  int   rf_lat = 1;
  logic [15:0] rf_corrupt = 16'h0;
  logic [15:0] regs [0:255];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input logic [63:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0h expected nothing", nm, act);
  endtask

  initial forever begin
    @(posedge clk_mst);
    cyc++;
    rst_q = rst_n;
  end

  // Monitor: pops expectations whenever the DUT presents a write, a word or a job-end pulse.
  initial begin
    @(posedge clk_mst);
    forever begin
      @(negedge clk_mst);
      if (!rst_q) begin
        check("reset_outputs", {job_ready_o, src_ready_o, valid_o, write, read, job_done_o, job_err_o,
                                addr, wdata, data_o}, 64'd0);
        hs_seen = 0;
        idle_run = 0;
      end else begin
        if (write) begin
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
          last_wr_cyc = cyc;
          if (exp_wr.size() == 0) fail("unexpected_write", {addr, wdata});
          else check("reg_write", {addr, wdata}, exp_wr.pop_front());
        end
        if (job_done_o) check("drain_idle_cycles", idle_run, DC);
        if (valid_o) begin
          idle_run = 0;
          if (exp_word.size() == 0) fail("unexpected_word", data_o);
          else check("stream_word", data_o, exp_word.pop_front());
        end else if (busy_i) idle_run = 0;
        else idle_run++;
        if (busy_i) check("ready_low_while_busy", src_ready_o, 0);
        if (job_done_o || job_err_o) begin
          end_cyc = cyc;
          if (exp_end.size() == 0) fail("unexpected_end", {job_done_o, job_err_o});
          else check("end_kind", {job_done_o, job_err_o}, exp_end.pop_front() ? 64'd1 : 64'd2);
        end
        if (job_valid_i && job_ready_o) acc_cyc = cyc;
        hs_seen = src_valid_i && src_ready_o;
        if (hs_seen && first_hs_cyc < 0) first_hs_cyc = cyc;
      end
    end
  end

  // Host source and busy model.
  initial forever begin
    @(posedge clk_mst);
    if (hs_seen && src_q.size() > 0) begin
      void'(src_q.pop_front());
      taken++;
      if (taken == 1 && busy_after_first) busy_hold = 5;
    end
    #1;
    if (busy_hold > 0) begin
      busy_i = 1'b1;
      busy_hold--;
    end else begin
      busy_i = rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    src_valid_i = (src_q.size() > 0) && (!src_gaps || $urandom_range(0, 3) != 0);
    src_data_i  = (src_q.size() > 0) ? src_q[0] : $urandom;
  end

  // Register file responder: done (and optional error) rf_lat cycles after an access; rf_lat 0 withholds.
  initial begin
    logic [7:0]  a;
    logic [15:0] w;
    bit          is_rd;
    forever begin
      @(negedge clk_mst);
      if (rst_q && (write || read)) begin
        a = addr; w = wdata; is_rd = read;
        if (!is_rd) regs[a] = w;
        if (rf_lat > 0) begin
          repeat (rf_lat) @(posedge clk_mst);
          #1;
          done  = 1'b1;
          error = rf_err_key && (a != 8'h00);
          rdata = is_rd ? (regs[a] ^ rf_corrupt) : 16'h0;
          @(posedge clk_mst);
          #1;
          done  = 1'b0;
          error = 1'b0;
        end
      end
    end
  end

  task automatic flush();
    exp_wr.delete(); exp_word.delete(); exp_end.delete(); src_q.delete();
    busy_hold = 0;
  endtask

  task automatic wait_job_end();
    int n = 0;
    while (exp_end.size() != 0 && n < 3000) begin
      @(negedge clk_mst);
      n++;
    end
    if (exp_end.size() != 0) begin
      fail("job_end_timeout", exp_end.size());
      flush();
    end
    check("words_left", exp_word.size(), 0);
    check("writes_left", exp_wr.size(), 0);
    @(negedge clk_mst);
  endtask

  // Reference: valid alg & len -> key write to 0x10+2*alg, select write {0,alg}, len words, done;
  // otherwise, or on a register failure, an error pulse and nothing further.
  task automatic run_job(input logic [1:0] alg, input logic [15:0] key, input logic [15:0] len,
                         input int lat, input bit rerr, input bit wait_end);
    bit good, sel_ok;
    logic [31:0] w;
    int n;
    good   = (alg != 2'd3) && (len != 16'd0);
    sel_ok = good && (lat > 0) && !rerr && (rf_corrupt == 16'h0);
    rf_lat = lat; rf_err_key = rerr;
    taken = 0; first_wr_cyc = -1; first_hs_cyc = -1;
    if (good) exp_wr.push_back({8'(8'h10 + 2 * alg), key});
    if (sel_ok) begin
      exp_wr.push_back({8'h00, 14'h0, alg});
      for (int i = 0; i < int'(len); i++) begin
        w = $urandom;
        exp_word.push_back(w);
        src_q.push_back(w);
      end
    end
    exp_end.push_back(!sel_ok);
    @(posedge clk_mst);
    #1;
    job_valid_i = 1'b1; job_alg_i = alg; job_key_i = key; job_len_i = len;
    n = 0;
    do begin
      @(negedge clk_mst);
      n++;
    end while (!job_ready_o && n < 200);
    if (!job_ready_o) fail("accept_timeout", n);
    @(posedge clk_mst);
    #1;
    job_valid_i = 1'b0;
    job_alg_i = 2'($urandom); job_key_i = 16'($urandom); job_len_i = 16'($urandom);
    if (wait_end) wait_job_end();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [1:0]  ra;
    logic [15:0] rl;
    int n;
    repeat (3) @(posedge clk_mst);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk_mst);
    check("ready_after_reset", job_ready_o, 1);

    // caesar, key 3, len 4, done one cycle after each write
    run_job(2'd0, 16'h0003, 16'd4, 1, 0, 1);
    check("write_to_stream_latency_ge4", (first_hs_cyc - first_wr_cyc) >= 4, 1);

    // scytale len 3 with busy_i high for 5 cycles after the first word
    busy_after_first = 1;
    run_job(2'd1, 16'h00a5, 16'd3, 1, 0, 1);
    busy_after_first = 0;

    // illegal alg and zero length
    run_job(2'd3, 16'h1234, 16'd4, 1, 0, 1);
    check("err_latency_alg3", end_cyc - acc_cyc, 1);
    run_job(2'd2, 16'h1234, 16'd0, 1, 0, 1);
    check("err_latency_len0", end_cyc - acc_cyc, 1);

    // done withheld after the key write
    run_job(2'd0, 16'h0042, 16'd4, 0, 0, 1);
    check("timeout_cycles", end_cyc - last_wr_cyc, RT);
    check("ready_after_timeout", job_ready_o, 1);

    // reset during stream word 2 of 6, then a clean job
    run_job(2'd1, 16'h0007, 16'd6, 1, 0, 0);
    n = 0;
    while (taken < 2 && n < 500) begin
      @(negedge clk_mst);
      n++;
    end
    if (taken < 2) fail("reset_test_stream_start", taken);
    @(posedge clk_mst);
    #1 rst_n = 1'b0;
    @(posedge clk_mst);
    #1 flush();
    @(posedge clk_mst);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk_mst);
    check("no_pulse_after_reset", exp_end.size(), 0);
    run_job(2'd2, 16'h0011, 16'd5, 2, 0, 1);

`ifdef READBACK_VERIFY_EN
    // readback returns 0x0004 after 0x0005 was written
    rf_corrupt = 16'h0001;
    run_job(2'd0, 16'h0005, 16'd4, 1, 0, 1);
    rf_corrupt = 16'h0000;
`endif

    // randomized jobs
    rand_busy = 1;
    src_gaps  = 1;
    for (int j = 0; j < 12; j++) begin
      ra = 2'($urandom_range(0, 3));
      rl = 16'($urandom_range(0, 8));
      run_job(ra, 16'($urandom), rl, int'($urandom_range(1, 3)), $urandom_range(0, 7) == 0, 1);
    end
    rand_busy = 0;
    src_gaps  = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
